// File: rtl/led_pattern_sequencer.sv
// Five-state LED pattern sequencer: OFF, BLINK, CHASE, DIM, ON.
// A prescaler makes update ticks; each state lasts TICKS_PER_STATE ticks, or until STEP forces an advance.
module led_pattern_sequencer #(
  parameter int CYCLES_PER_TICK = 16000000,
  parameter int TICKS_PER_STATE = 4,
  parameter int NUM_LEDS        = 1,
  parameter int PWM_BITS        = 4,
  parameter int DIM_DUTY        = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                STEP,
  output logic [NUM_LEDS-1:0] LED,
  output logic [2:0]          STATE,
  output logic                TICK,
  output logic                USBPU
);

  localparam int PW = $clog2(CYCLES_PER_TICK);
  localparam int TW = (TICKS_PER_STATE > 1) ? $clog2(TICKS_PER_STATE) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CYCLES_PER_TICK - 1);
  localparam logic [TW-1:0]     TCNT_LAST  = TW'(TICKS_PER_STATE - 1);
  localparam logic [PWM_BITS:0] DUTY       = (PWM_BITS+1)'(DIM_DUTY);

  if (CYCLES_PER_TICK < 2 || TICKS_PER_STATE < 1 || NUM_LEDS < 1 || NUM_LEDS > 16 ||
      PWM_BITS < 1 || DIM_DUTY < 0 || DIM_DUTY > (1 << PWM_BITS)) begin : g_param_err
    $error("led_pattern_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_BLINK = 3'd1,
    S_CHASE = 3'd2,
    S_DIM   = 3'd3,
    S_ON    = 3'd4
  } state_t;

  state_t                state;
  logic [PW-1:0]         presc;
  logic [TW-1:0]         tcnt;
  logic                  phase;
  logic [NUM_LEDS-1:0]   ptr;
  logic [PWM_BITS-1:0]   pwm;

  logic                  tick_ev, last_tick, adv, illegal, dim_on;
  logic [NUM_LEDS-1:0]   ptr_rot;

  function automatic state_t nxt(input state_t s);
    case (s)
      S_OFF:   nxt = S_BLINK;
      S_BLINK: nxt = S_CHASE;
      S_CHASE: nxt = S_DIM;
      S_DIM:   nxt = S_ON;
      default: nxt = S_OFF;
    endcase
  endfunction

  assign tick_ev   = EN && (presc == PRESC_LAST);
  assign last_tick = (tcnt == TCNT_LAST);
  assign adv       = STEP || (tick_ev && last_tick);
  assign illegal   = (state > S_ON);
  // Shift-or rotate collapses to "hold" when there is a single LED.
  assign ptr_rot   = (ptr << 1) | (ptr >> (NUM_LEDS - 1));
  assign dim_on    = ({1'b0, pwm} < DUTY);

  assign STATE = state;
  assign USBPU = 1'b0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_OFF;
      presc <= '0;
      tcnt  <= '0;
      phase <= 1'b0;
      ptr   <= '0;
      pwm   <= '0;
      LED   <= '0;
      TICK  <= 1'b0;
    end else begin
      TICK <= tick_ev && !STEP;
      if (EN) pwm <= pwm + PWM_BITS'(1);

      // STEP wins over a coincident tick so the state advances only once.
      if (STEP) begin
        presc <= '0;
        tcnt  <= '0;
      end else if (tick_ev) begin
        presc <= '0;
        tcnt  <= last_tick ? '0 : tcnt + TW'(1);
      end else if (EN) begin
        presc <= presc + PW'(1);
      end

      if (adv || illegal) begin
        state <= nxt(state);
        phase <= 1'b0;
        ptr   <= NUM_LEDS'(1);
      end else if (tick_ev) begin
        phase <= ~phase;
        ptr   <= ptr_rot;
      end

      case (state)
        S_BLINK: LED <= {NUM_LEDS{phase}};
        S_CHASE: LED <= ptr;
        S_DIM:   LED <= {NUM_LEDS{dim_on}};
        S_ON:    LED <= '1;
        default: LED <= '0;
      endcase
    end
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Parametrised successor to the board's single-LED state-machine blinker.
- Drives NUM_LEDS outputs through a fixed five-state pattern sequence: OFF, BLINK, CHASE, DIM, ON.
- Adds a pause enable, a manual step input, a PWM dim mode and a multi-LED chase.
- Sits in top-level board logic, clocked by the 16 MHz board clock; its outputs feed pins directly.

Parameters:
- CYCLES_PER_TICK, 16000000, clock cycles per update tick; legal range >= 2.
- TICKS_PER_STATE, 4, update ticks spent in each state; legal range >= 1.
- NUM_LEDS, 1, number of LED outputs; legal range 1..16.
- PWM_BITS, 4, width of the free-running PWM counter used in DIM.
- DIM_DUTY, 4, PWM on-count in DIM; legal range 0..2^PWM_BITS.

Ports:
- CLK  input  1  board clock.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  1 = run, 0 = pause; prescaler, tick counter and PWM counter hold.
- STEP  input  1  synchronous single-cycle pulse; forces an advance to the next state.
- LED  output  NUM_LEDS  pattern outputs, registered.
- STATE  output  3  current state encoding, registered.
- TICK  output  1  one-cycle pulse on each update tick.
- USBPU  output  1  constant 0; disables the USB pull-up.

Behaviour:
- State encoding: OFF=0, BLINK=1, CHASE=2, DIM=3, ON=4.
  - Sequence: OFF→BLINK→CHASE→DIM→ON→OFF.
  - Codes 5–7 are illegal and go to OFF on the next cycle.
- Reset (RST_N=0, asynchronous assert):
  - STATE=OFF; LED=0; TICK=0.
  - Prescaler, tick counter, blink phase, chase pointer and PWM counter all 0.
  - Reset release is synchronous to CLK.
  - Reset mid-state discards all progress.
- Prescaler:
  - Counts 0..CYCLES_PER_TICK-1 while EN=1, then wraps.
  - The tick event is prescaler==CYCLES_PER_TICK-1 with EN=1.
  - TICK is registered and goes high in the cycle after the tick event.
- Tick counter:
  - Counts 0..TICKS_PER_STATE-1, incrementing on each tick event.
  - A tick event at TICKS_PER_STATE-1 advances the state and clears the tick counter.
  - State dwell is exactly CYCLES_PER_TICK*TICKS_PER_STATE enabled cycles.
- STEP:
  - When STEP=1 (regardless of EN), the next cycle advances the state.
  - Prescaler and tick counter clear to 0; TICK stays 0 for that event.
  - STEP coinciding with a terminal tick event advances exactly once.
  - STEP held high advances once per cycle.
- State entry, from either advance source:
  - Blink phase clears to 0.
  - Chase pointer becomes one-hot bit 0.
- BLINK: blink phase toggles on each tick event; every LED bit equals the phase.
- CHASE:
  - The pointer rotates left by one on each tick event, wrapping bit NUM_LEDS-1 to bit 0.
  - With NUM_LEDS=1 the pointer stays at 1.
  - LED = pointer.
- DIM:
  - PWM counter is free-running, PWM_BITS wide, incrementing each enabled cycle and wrapping.
  - Every LED bit = (PWM counter < DIM_DUTY).
  - DIM_DUTY=0 gives always off; DIM_DUTY=2^PWM_BITS gives always on.
  - Comparison is done PWM_BITS+1 wide.
- OFF: LED=0. ON: LED = all ones.
- Output latency:
  - LED is a registered function of the current state and its internal counters, so LED lags any state change by 1 cycle.
  - STATE updates in the same cycle as the internal state.
- Pause (EN=0): LED holds its pattern; in DIM it freezes at its current level.
- Counter widths:
  - Prescaler: $clog2(CYCLES_PER_TICK).
  - Tick counter: max(1, $clog2(TICKS_PER_STATE)).
- Illegal parameter values are rejected by an elaboration-time check.

Test Plan:
Bench parameters: CYCLES_PER_TICK=4, TICKS_PER_STATE=2, NUM_LEDS=4, PWM_BITS=2, DIM_DUTY=1.
1. Reset, then EN=1 for 40 cycles:
   - STATE sequence is 0,1,2,3,4, changing every 8 cycles, then wraps to 0 at cycle 40.
   - TICK pulses every 4 cycles.
2. In BLINK: LED=0000 for 4 cycles, then 1111 for 4 cycles; phase is 0 on entry.
3. CHASE with NUM_LEDS=4 and TICKS_PER_STATE=6: LED goes 0001, 0010, 0100, 1000, 0001, 0010, one value per tick (wrap verified).
4. In DIM: LED=1111 for 1 cycle, then 0000 for 3, repeating. Hold EN=0 for 10 cycles: LED, STATE and prescaler frozen.
5. STEP pulse mid-state (tick counter=1, prescaler=2):
   - STATE advances next cycle.
   - Next natural advance occurs exactly 8 cycles later.
   - STEP on a terminal tick gives a single advance.
6. Assert RST_N=0 asynchronously mid-CHASE with LED=0100: LED=0 and STATE=0 before the next CLK edge; after release the sequence restarts from OFF.
